// File: rtl/bnn_pkg.sv
// Shared geometry of the fc_12 binary fully-connected unit and the sequencer state encoding.
package bnn_pkg;

  localparam int FC_N_CH        = 12;
  localparam int FC_WEIGHT_BITS = 144;
  localparam int FC_IN_LEN      = 12;
  localparam int FC_DW          = 16;
  localparam int FC_N_OUT       = 10;
  localparam int FC_OV_TIMEOUT  = 255;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_W = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_FEED   = 3'd3;
  localparam logic [2:0] ST_WAIT_O = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_W = ST_LOAD_W,
    GAP    = ST_GAP,
    FEED   = ST_FEED,
    WAIT_O = ST_WAIT_O,
    DONE   = ST_DONE
  } seq_state_e;

  // Index/counter width that stays at least one bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_argmax.sv
// Streaming signed max/index tracker; a strict greater-than compare makes ties keep the lower index.
module fc_argmax
  import bnn_pkg::*;
#(
  parameter int DW = FC_DW,
  parameter int IW = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 valid,
  input  logic signed [DW-1:0] value,
  input  logic [IW-1:0]        idx,
  output logic signed [DW-1:0] max_val,
  output logic [IW-1:0]        max_idx
);

  // Clear seeds the most-negative value so an all-negative run still selects a real winner.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (clear) begin
      max_val <= {1'b1, {(DW-1){1'b0}}};
      max_idx <= '0;
    end else if (valid && (value > max_val)) begin
      max_val <= value;
      max_idx <= idx;
    end
  end

endmodule

// File: rtl/fc_seq_ctrl.sv
// Sequencer for fc_12: per neuron it streams serial weights, then feature words, then captures
// the signed result; after the last neuron it reports the argmax class.
module fc_seq_ctrl
  import bnn_pkg::*;
#(
  parameter int  N_OUT       = FC_N_OUT,
  parameter int  WEIGHT_BITS = FC_WEIGHT_BITS,
  parameter int  IN_LEN      = FC_IN_LEN,
  parameter int  N_CH        = FC_N_CH,
  parameter int  DW          = FC_DW,
  parameter int  OV_TIMEOUT  = FC_OV_TIMEOUT,
  localparam int WA_W        = idx_width(N_OUT * WEIGHT_BITS),
  localparam int FA_W        = idx_width(IN_LEN),
  localparam int IDX_W       = idx_width(N_OUT)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 w_rd,
  output logic [WA_W-1:0]      w_addr,
  input  logic                 w_bit,
  output logic                 f_rd,
  output logic [FA_W-1:0]      f_addr,
  input  logic [N_CH-1:0]      f_data,
  output logic                 fc_weight,
  output logic                 fc_weight_en,
  output logic                 fc_ivalid,
  output logic [N_CH-1:0]      fc_din,
  input  logic                 fc_ovalid,
  input  logic signed [DW-1:0] fc_dout,
  output logic                 res_valid,
  output logic [IDX_W-1:0]     res_idx,
  output logic signed [DW-1:0] res_data,
  output logic [IDX_W-1:0]     class_id,
  output logic signed [DW-1:0] class_max
);

  localparam int BC_W = idx_width(WEIGHT_BITS);
  localparam int TC_W = idx_width(OV_TIMEOUT);

  seq_state_e        state, state_nxt;
  logic [BC_W-1:0]   b_cnt;
  logic [TC_W-1:0]   t_cnt;
  logic [IDX_W-1:0]  n_cnt;
  logic              accept, last_bit, last_feed, last_neuron, ov_hit, timeout;

  assign accept      = (state == IDLE) && start;
  assign last_bit    = (b_cnt == BC_W'(WEIGHT_BITS - 1));
  assign last_feed   = (f_addr == FA_W'(IN_LEN - 1));
  assign last_neuron = (n_cnt == IDX_W'(N_OUT - 1));
  assign ov_hit      = (state == WAIT_O) && fc_ovalid;
  assign timeout     = (state == WAIT_O) && !fc_ovalid && (t_cnt == TC_W'(OV_TIMEOUT - 1));

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    w_rd      = 1'b0;
    f_rd      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:   if (start) state_nxt = LOAD_W;
      LOAD_W: begin
        w_rd = 1'b1;
        busy = 1'b1;
        if (last_bit) state_nxt = GAP;
      end
      GAP:    begin
        busy      = 1'b1;
        state_nxt = FEED;
      end
      FEED:   begin
        f_rd = 1'b1;
        busy = 1'b1;
        if (last_feed) state_nxt = WAIT_O;
      end
      WAIT_O: begin
        busy = 1'b1;
        if (fc_ovalid)    state_nxt = last_neuron ? DONE : LOAD_W;
        else if (timeout) state_nxt = DONE;
      end
      DONE:   begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // w_addr runs straight across neurons, so neuron n starts at n*WEIGHT_BITS without a multiply.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_addr    <= '0;
      b_cnt     <= '0;
      f_addr    <= '0;
      t_cnt     <= '0;
      n_cnt     <= '0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          err    <= 1'b0;
          n_cnt  <= '0;
          w_addr <= '0;
          b_cnt  <= '0;
          f_addr <= '0;
        end
        LOAD_W: begin
          w_addr <= w_addr + 1'b1;
          b_cnt  <= last_bit ? '0 : b_cnt + 1'b1;
        end
        FEED: begin
          f_addr <= last_feed ? '0 : f_addr + 1'b1;
          if (last_feed) t_cnt <= '0;
        end
        WAIT_O: begin
          if (fc_ovalid) begin
            res_valid <= 1'b1;
            res_idx   <= n_cnt;
            res_data  <= fc_dout;
            if (!last_neuron) n_cnt <= n_cnt + 1'b1;
          end else begin
            t_cnt <= t_cnt + 1'b1;
            if (timeout) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory read data lands one cycle after the strobe; the enables are delayed to match it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fc_weight_en <= 1'b0;
      fc_ivalid    <= 1'b0;
    end else begin
      fc_weight_en <= w_rd;
      fc_ivalid    <= f_rd;
    end
  end

  // Data is gated by its enable so fc_12 sees quiet lines outside a transfer.
  assign fc_weight = w_bit & fc_weight_en;
  assign fc_din    = fc_ivalid ? f_data : '0;

  fc_argmax #(
    .DW (DW),
    .IW (IDX_W)
  ) u_argmax (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (accept),
    .valid   (ov_hit),
    .value   (fc_dout),
    .idx     (n_cnt),
    .max_val (class_max),
    .max_idx (class_id)
  );

endmodule
